// File: rtl/sized_data_memory_pkg.sv
// Shared types and lane helpers for the sized data memory.
// Lane helpers work on a big-endian window of two consecutive words.
package sized_data_memory_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } access_size_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SECOND = 1'b1
   } state_t;

   // Helpers are sized for the widest supported word; callers cast down.
   localparam int MAX_WIDTH = 256;
   localparam int MAX_LANES = 2 * MAX_WIDTH / 8;

   function automatic int unsigned sizeBytes(input logic [1:0] size);
      return 32'd1 << size;
   endfunction

   function automatic int unsigned laneShift(input int unsigned off, input int unsigned n,
                                             input int unsigned bytes);
      return (2 * bytes) - off - n;
   endfunction

   function automatic logic [MAX_LANES-1:0] byteMask(input int unsigned off, input int unsigned n,
                                                     input int unsigned bytes);
      return ((MAX_LANES'(1) << n) - MAX_LANES'(1)) << laneShift(off, n, bytes);
   endfunction

   function automatic logic [MAX_WIDTH-1:0] extendField(input logic [MAX_WIDTH-1:0] field,
                                                        input int unsigned n, input logic sgn);
      logic [MAX_WIDTH-1:0] keep;
      logic [MAX_WIDTH-1:0] res;
      keep = (MAX_WIDTH'(1) << (8 * n)) - MAX_WIDTH'(1);
      res  = field & keep;
      if (sgn && field[8*n-1]) begin
         res = res | ~keep;
      end
      return res;
   endfunction

endpackage

// File: rtl/sized_data_memory_ram.sv
// Single-port synchronous RAM with per-lane write enables.
// A read of the word being written returns its old contents.
module byte_enable_ram #(
   parameter int    WIDTH     = 32,
   parameter int    DEPTH     = 64,
   parameter string INIT_FILE = ""
) (
   input  logic                     i_clk,
   input  logic [$clog2(DEPTH)-1:0] i_addr,
   input  logic [WIDTH/8-1:0]       i_we,
   input  logic [WIDTH-1:0]         i_wdata,
   output logic [WIDTH-1:0]         o_rdata
);
   localparam int BYTES = WIDTH / 8;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Registered read of the addressed word, with per-lane writes committed at the same edge.
   always_ff @(posedge i_clk) begin
      r_rdata <= r_mem[i_addr];
      for (int b = 0; b < BYTES; b++) begin
         if (i_we[b]) begin
            r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/sized_data_memory.sv
// Byte/half/word load-store data memory with big-endian lane order.
// Word-straddling accesses are split into two RAM beats with the request side stalled.
module sized_data_memory
   import sized_data_memory_pkg::*;
#(
   parameter int    WIDTH     = 32,
   parameter int    DEPTH     = 64,
   parameter string INIT_FILE = "cpu/init/data.hex"
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [1:0]       req_size,
   input  logic             req_signed,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_error
);
   localparam int BYTES = WIDTH / 8;
   localparam int OFFW  = $clog2(BYTES);
   localparam int AW    = $clog2(DEPTH);
   localparam int WW    = 2 * WIDTH;
   localparam int LANES = 2 * BYTES;

   state_t           r_state;
   logic             r_write;
   access_size_t     r_size;
   logic             r_signed;
   logic [OFFW-1:0]  r_off;
   logic             r_span;
   logic [AW-1:0]    r_addr2;
   logic [WIDTH-1:0] r_wdataLo;
   logic [BYTES-1:0] r_maskLo;
   logic [WIDTH-1:0] r_hold;
   logic             r_respValid;
   logic             r_respError;

   logic [OFFW-1:0]  w_off;
   logic [WIDTH-1:0] w_word;
   logic [AW-1:0]    w_addr;
   int unsigned      w_n;
   logic             w_span;
   logic             w_err;
   logic             w_accept;
   int unsigned      w_wShift;
   logic [WIDTH-1:0] w_wField;
   logic [WW-1:0]    w_wWin;
   logic [LANES-1:0] w_mWin;
   logic [AW-1:0]    w_ramAddr;
   logic [BYTES-1:0] w_ramWe;
   logic [WIDTH-1:0] w_ramWdata;
   logic [WIDTH-1:0] w_ramQ;
   int unsigned      w_rN;
   logic [WW-1:0]    w_rdWin;
   logic [WIDTH-1:0] w_rdField;
   logic [WIDTH-1:0] w_rdExt;

   // Store data and lane mask are laid out over a {word, word+1} window; the upper
   // half drives beat 1 and the lower half is held for beat 2.
   always_comb begin
      w_off    = req_addr[OFFW-1:0];
      w_word   = req_addr >> OFFW;
      w_addr   = w_word[AW-1:0];
      w_n      = sizeBytes(req_size);
      w_span   = (32'(w_off) + w_n) > 32'(BYTES);
      w_err    = (req_size == 2'd3) || (w_n > 32'(BYTES)) || (w_word >= WIDTH'(DEPTH))
                 || (w_span && ((w_word + WIDTH'(1)) >= WIDTH'(DEPTH)));
      w_wShift = laneShift(32'(w_off), w_n, 32'(BYTES));
      w_wField = WIDTH'(extendField(MAX_WIDTH'(req_wdata), w_n, 1'b0));
      w_wWin   = WW'(w_wField) << (8 * w_wShift);
      w_mWin   = LANES'(byteMask(32'(w_off), w_n, 32'(BYTES)));
   end

   assign req_ready = (r_state == ST_IDLE);
   assign w_accept  = req_valid && req_ready;

   always_comb begin
      w_ramAddr  = w_addr;
      w_ramWe    = '0;
      w_ramWdata = w_wWin[WW-1:WIDTH];
      if (r_state == ST_SECOND) begin
         w_ramAddr  = r_addr2;
         w_ramWdata = r_wdataLo;
         if (r_write) begin
            w_ramWe = r_maskLo;
         end
      end else if (w_accept && req_write && !w_err) begin
         w_ramWe = w_mWin[LANES-1:BYTES];
      end
   end

   byte_enable_ram #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .INIT_FILE(INIT_FILE)
   ) u_ram (
      .i_clk  (clk),
      .i_addr (w_ramAddr),
      .i_we   (w_ramWe),
      .i_wdata(w_ramWdata),
      .o_rdata(w_ramQ)
   );

   // Request info latched at acceptance also describes the response that follows it,
   // since nothing new can be accepted before that response is presented.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state     <= ST_IDLE;
         r_write     <= 1'b0;
         r_size      <= SIZE_BYTE;
         r_signed    <= 1'b0;
         r_off       <= '0;
         r_span      <= 1'b0;
         r_addr2     <= '0;
         r_wdataLo   <= '0;
         r_maskLo    <= '0;
         r_hold      <= '0;
         r_respValid <= 1'b0;
         r_respError <= 1'b0;
      end else begin
         r_respValid <= 1'b0;
         r_respError <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_write   <= req_write;
                  r_size    <= w_err ? SIZE_BYTE : access_size_t'(req_size);
                  r_signed  <= req_signed;
                  r_off     <= w_off;
                  r_span    <= w_span && !w_err;
                  r_addr2   <= w_addr + AW'(1);
                  r_wdataLo <= w_wWin[WIDTH-1:0];
                  r_maskLo  <= w_mWin[BYTES-1:0];
                  if (w_span && !w_err) begin
                     r_state <= ST_SECOND;
                  end else begin
                     r_respValid <= 1'b1;
                     r_respError <= w_err;
                  end
               end
            end
            ST_SECOND: begin
               if (!r_write) begin
                  r_hold <= w_ramQ;
               end
               r_respValid <= 1'b1;
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Loads reassemble the same window: held beat-1 word on top, current RAM output below.
   always_comb begin
      w_rN      = sizeBytes(r_size);
      w_rdWin   = r_span ? {r_hold, w_ramQ} : {w_ramQ, {WIDTH{1'b0}}};
      w_rdField = WIDTH'(w_rdWin >> (8 * laneShift(32'(r_off), w_rN, 32'(BYTES))));
      w_rdExt   = WIDTH'(extendField(MAX_WIDTH'(w_rdField), w_rN, r_signed));
   end

   assign resp_valid = r_respValid;
   assign resp_error = r_respError;
   assign resp_rdata = (r_respValid && !r_respError && !r_write) ? w_rdExt : '0;

   illegalSizeNoWrite: assert property (@(posedge clk) disable iff (!nreset)
      (w_accept && req_size == 2'd3) |-> (w_ramWe == '0));

endmodule

// File: tb/tb_sized_data_memory.sv
// Self-checking bench for sized_data_memory: directed cases with fixed expected values,
// then randomized traffic checked against a byte-array memory model.
module tb_sized_data_memory;

   localparam int WIDTH    = 32;
   localparam int DEPTH    = 64;
   localparam int MEMBYTES = DEPTH * WIDTH / 8;

   logic             clk = 1'b0;
   logic             nreset = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic             req_write = 1'b0;
   logic [1:0]       req_size = 2'd0;
   logic             req_signed = 1'b0;
   logic [WIDTH-1:0] req_addr = '0;
   logic [WIDTH-1:0] req_wdata = '0;
   logic             resp_valid;
   logic [WIDTH-1:0] resp_rdata;
   logic             resp_error;

   sized_data_memory #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .INIT_FILE("")
   ) dut (
      .clk       (clk),
      .nreset    (nreset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_size  (req_size),
      .req_signed(req_signed),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .resp_error(resp_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic [7:0] model [MEMBYTES];

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   exp_t  expQ[$];
   string tagQ[$];
   exp_t  monE;
   string monTag;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference behaviour: plain byte-addressed memory, bytes taken in address order.
   function automatic void modelAccess(input logic wr, input logic [1:0] size, input logic sgn,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rdata, output logic err,
                                       output logic span);
      longint unsigned a;
      longint unsigned v;
      int n;
      a     = 64'(addr);
      n     = 1 << size;
      v     = 0;
      rdata = '0;
      err   = (size == 2'd3) || (a + 64'(n) > 64'(MEMBYTES));
      span  = !err && ((a % 4) + 64'(n) > 4);
      if (err) return;
      if (wr) begin
         for (int i = 0; i < n; i++) model[a + 64'(i)] = wdata[8*(n-1-i) +: 8];
      end else begin
         for (int i = 0; i < n; i++) v = (v << 8) | 64'(model[a + 64'(i)]);
         if (sgn && v[8*n-1]) v = v | (~64'd0 << (8*n));
         rdata = v[31:0];
      end
   endfunction

   task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input string tag, input logic useExp,
                                input logic [31:0] expData);
      exp_t        e;
      logic [31:0] mr;
      logic        merr;
      logic        mspan;
      int          waitCnt;
      waitCnt = 0;
      while (!req_ready && waitCnt < 20) begin
         @(negedge clk);
         waitCnt++;
      end
      checkOutput({tag, "/ready"}, 64'(req_ready), 64'(1));
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      modelAccess(wr, size, sgn, addr, wdata, mr, merr, mspan);
      e.rdata = useExp ? expData : mr;
      e.err   = merr;
      e.due   = cyc + 1 + (mspan ? 1 : 0);
      expQ.push_back(e);
      tagQ.push_back(tag);
      @(negedge clk);
      req_valid = 1'b0;
      if (mspan) checkOutput({tag, "/stall"}, 64'(req_ready), 64'(0));
   endtask

   task automatic waitDrain(input string tag);
      int k;
      k = 0;
      while (expQ.size() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      checkOutput({tag, "/drain"}, 64'(expQ.size()), 64'(0));
   endtask

   task automatic loadImage();
      applyStimulus(1'b1, 2'd2, 1'b0, 32'd0, 32'h11223344, "img0", 1'b0, 32'd0);
      applyStimulus(1'b1, 2'd2, 1'b0, 32'd4, 32'h55667788, "img1", 1'b0, 32'd0);
   endtask

   // Every response is matched in order against the queue, including its arrival cycle.
   always @(negedge clk) begin
      if (nreset && resp_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("spuriousResp", 64'(resp_valid), 64'(0));
         end else begin
            monE   = expQ.pop_front();
            monTag = tagQ.pop_front();
            checkOutput({monTag, "/rdata"}, 64'(resp_rdata), 64'(monE.rdata));
            checkOutput({monTag, "/error"}, 64'(resp_error), 64'(monE.err));
            checkOutput({monTag, "/latency"}, 64'(cyc), 64'(monE.due));
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic        wr;
      logic        sgn;
      logic [1:0]  sz;
      logic [31:0] addr;

      repeat (3) @(negedge clk);
      checkOutput("reset/ready", 64'(req_ready), 64'(1));
      checkOutput("reset/respValid", 64'(resp_valid), 64'(0));
      checkOutput("reset/respError", 64'(resp_error), 64'(0));
      checkOutput("reset/respRdata", 64'(resp_rdata), 64'(0));
      nreset = 1'b1;
      @(negedge clk);

      for (int w = 0; w < DEPTH; w++)
         applyStimulus(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, "fill", 1'b0, 32'd0);
      loadImage();

      applyStimulus(1'b0, 2'd2, 1'b0, 32'd0, 32'd0, "ldW0", 1'b1, 32'h11223344);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'd4, 32'd0, "ldW4", 1'b1, 32'h55667788);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'd2, 32'd0, "ldSpanW2", 1'b1, 32'h33445566);
      applyStimulus(1'b0, 2'd0, 1'b1, 32'd7, 32'd0, "ldBS7", 1'b1, 32'hFFFFFF88);
      applyStimulus(1'b0, 2'd0, 1'b0, 32'd7, 32'd0, "ldBU7", 1'b1, 32'h00000088);
      applyStimulus(1'b0, 2'd1, 1'b1, 32'd4, 32'd0, "ldHS4", 1'b1, 32'h00005566);
      applyStimulus(1'b0, 2'd1, 1'b1, 32'd3, 32'd0, "ldHS3", 1'b1, 32'h00004455);

      applyStimulus(1'b1, 2'd2, 1'b0, 32'd3, 32'hAABBCCDD, "stSpanW3", 1'b0, 32'd0);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'd0, 32'd0, "ldAfterSt0", 1'b1, 32'h112233AA);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'd4, 32'd0, "ldAfterSt4", 1'b1, 32'hBBCCDD88);

      loadImage();
      applyStimulus(1'b1, 2'd0, 1'b0, 32'd5, 32'h000000EE, "stB5", 1'b0, 32'd0);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'd4, 32'd0, "ldAfterStB", 1'b1, 32'h55EE7788);

      loadImage();
      applyStimulus(1'b0, 2'd2, 1'b0, 32'hFE, 32'd0, "errSpanEnd", 1'b1, 32'd0);
      applyStimulus(1'b0, 2'd3, 1'b0, 32'd0, 32'd0, "errSize3Ld", 1'b1, 32'd0);
      applyStimulus(1'b1, 2'd3, 1'b0, 32'd0, 32'hDEADBEEF, "errSize3St", 1'b1, 32'd0);
      applyStimulus(1'b1, 2'd2, 1'b0, 32'hFE, 32'hCAFEF00D, "errSpanSt", 1'b1, 32'd0);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'd0, 32'd0, "ldAfterErr0", 1'b1, 32'h11223344);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'hFC, 32'd0, "ldAfterErrFC", 1'b0, 32'd0);

      for (int i = 0; i < 400; i++) begin
         wr   = 1'($urandom_range(0, 1));
         sgn  = 1'($urandom_range(0, 1));
         sz   = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 259));
         applyStimulus(wr, sz, sgn, addr, $urandom, $sformatf("rnd%0d", i), 1'b0, 32'd0);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      loadImage();
      waitDrain("preReset");
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_size   = 2'd2;
      req_signed = 1'b0;
      req_addr   = 32'd3;
      req_wdata  = 32'hAABBCCDD;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      checkOutput("rst/inSecond", 64'(req_ready), 64'(0));
      #1;
      nreset = 1'b0;
      #1;
      checkOutput("rst/ready", 64'(req_ready), 64'(1));
      checkOutput("rst/respValid", 64'(resp_valid), 64'(0));
      checkOutput("rst/respError", 64'(resp_error), 64'(0));
      checkOutput("rst/respRdata", 64'(resp_rdata), 64'(0));
      @(negedge clk);
      @(negedge clk);
      nreset = 1'b1;
      model[3] = 8'hAA;
      checkOutput("rst/readyAfter", 64'(req_ready), 64'(1));
      @(negedge clk);
      checkOutput("rst/noResp", 64'(resp_valid), 64'(0));
      applyStimulus(1'b0, 2'd2, 1'b0, 32'd0, 32'd0, "rstLd0", 1'b1, 32'h112233AA);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'd4, 32'd0, "rstLd4", 1'b1, 32'h55667788);

      waitDrain("final");
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
